// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end feeding a sequential shift-add unsigned multiplier.
// One product is in flight at a time; the result is held until the consumer takes it.
module mult_arbiter #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           req1_ready,
  output logic           res_valid,
  output logic           res_id,
  output logic [2*N-1:0] res_data,
  input  logic           res_ready,
  output logic           busy
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic           ptr_reg;
  logic           owner_reg;
  logic [N-1:0]   mcand_reg;
  logic [2*N-1:0] prod_reg;
  logic [CW-1:0]  cnt_reg;

  logic [1:0]     valid_vec;
  logic [1:0]     ready_vec;
  logic           grant_id;
  logic           accept;
  logic [N:0]     sum_next;

  assign valid_vec = {req1_valid, req0_valid};

  // Pointer only matters on contention; a lone requester always wins.
  assign grant_id = (valid_vec == 2'b11) ? ptr_reg : valid_vec[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == IDLE) && !reset && valid_vec[gi]
                             && (grant_id == (gi == 1));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;

  // Upper half plus multiplicand keeps its carry so the 2N-bit product never overflows.
  assign sum_next = {1'b0, prod_reg[2*N-1:N]} + {1'b0, mcand_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
      mcand_reg <= '0;
      prod_reg  <= '0;
      cnt_reg   <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mcand_reg <= grant_id ? req1_a : req0_a;
            prod_reg  <= {{N{1'b0}}, (grant_id ? req1_b : req0_b)};
            owner_reg <= grant_id;
            ptr_reg   <= ~grant_id;
            cnt_reg   <= '0;
            state_reg <= RUN;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          // Multiplier sits in the low half and is consumed LSB first as the product shifts in.
          if (prod_reg[0])
            prod_reg <= {sum_next, prod_reg[N-1:1]};
          else
            prod_reg <= {1'b0, prod_reg[2*N-1:1]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1))
            state_reg <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; afterwards wait for the handshake.
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_data  <= prod_reg;
            res_id    <= owner_reg;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter: a behavioural arbitration/product model predicts
// the grant, result and latency of every transaction.
module tb_mult_arbiter;

  localparam int N = 32;

  logic           clk;
  logic           reset;
  logic           req0_valid, req1_valid;
  logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic           res_valid, res_id;
  logic [2*N-1:0] res_data;
  logic           res_ready;
  logic           busy;

  int check_count = 0;
  int error_count = 0;
  logic ptr_model;
  logic last_res_id;

  mult_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge with reset released.
  task automatic apply_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_val("ready_in_reset", {62'd0, req1_ready, req0_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_val("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check_val("rst_res_id", {63'd0, res_id}, 64'd0);
    check_val("rst_res_data", res_data, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    ptr_model = 1'b0;
  endtask

  // Full transaction from request to result handshake, starting at a negedge in IDLE.
  task automatic run_txn(input bit v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                         input bit v1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                         input int hold, input bit keep_valid);
    logic         exp_g;
    logic [63:0]  exp_p;
    int           lat;
    bit           bad;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    exp_g = (v0 && v1) ? ptr_model : v1;
    exp_p = exp_g ? ({32'd0, a1} * {32'd0, b1}) : ({32'd0, a0} * {32'd0, b0});
    #1;
    check_val("grant_ready", {62'd0, req1_ready, req0_ready},
              exp_g ? 64'd2 : 64'd1);
    ptr_model = ~exp_g;
    @(posedge clk);
    lat = 0;
    bad = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (res_valid) break;
      if (req0_ready || req1_ready || !busy) bad = 1;
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      if (!keep_valid) begin
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      end
    end
    check_val("latency", lat, N + 1);
    check_val("run_ready_low", {63'd0, bad}, 64'd0);
    check_val("res_data", res_data, exp_p);
    check_val("res_id", {63'd0, res_id}, {63'd0, exp_g});
    last_res_id = res_id;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== exp_p || res_id !== exp_g ||
          req0_ready || req1_ready) bad = 1;
    end
    check_val("hold_stable", {63'd0, bad}, 64'd0);
    res_ready = 1'b1;
    if (!keep_valid) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check_val("exit_valid", {63'd0, res_valid}, 64'd0);
    check_val("exit_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    ptr_model = 1'b0;
    last_res_id = 1'b0;
    @(negedge clk);
    apply_reset();

    // Single request, max operands, zero operand.
    run_txn(1'b1, 32'd7, 32'd6, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    run_txn(1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_txn(1'b1, 32'd0, 32'h1234_5678, 1'b0, 32'd0, 32'd0, 0, 1'b0);

    // Backpressure in DONE for 10 cycles.
    run_txn(1'b1, 32'd1000, 32'd3000, 1'b0, 32'd0, 32'd0, 10, 1'b0);

    // Contention after reset: both continuously valid, ids must alternate from 0.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom, 0, i < 3);
      check_val("rr_sequence", {63'd0, last_res_id}, i % 2);
    end

    // Reset during RUN aborts the job; the next one must not see the stale product.
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd6;
    @(posedge clk);
    req0_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    apply_reset();
    check_val("abort_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    run_txn(1'b0, 32'd0, 32'd0, 1'b1, 32'd3, 32'd5, 0, 1'b0);

    // Randomized mix of requesters, operands and backpressure.
    for (int i = 0; i < 10; i++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      run_txn(v0, $urandom, $urandom, v1, $urandom, $urandom, $urandom_range(0, 5), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: N, default 32, operand width in bits; result width is 2*N.
REQ-002 Clock: clk, input, 1, rising-edge; the block uses one clock only.
REQ-003 Reset: reset, input, 1, synchronous and active-high.
REQ-004 req0_valid: input, 1, requester 0 has an operand pair pending.
REQ-005 req0_a, req0_b: input, N each, requester 0 unsigned operands.
REQ-006 req0_ready: output, 1, requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready: same as REQ-004..006, for requester 1.
REQ-008 res_valid: output, 1, result available.
REQ-009 res_id: output, 1, index of the requester that owns the result.
REQ-010 res_data: output, 2*N, unsigned product.
REQ-011 res_ready: input, 1, consumer accepts the result.
REQ-012 busy: output, 1, high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE: if any reqX_valid is high, grant exactly one requester, assert its reqX_ready combinationally in that cycle, and go to RUN.
REQ-015 Acceptance occurs when reqX_valid and reqX_ready are both high; on acceptance the operands and owner id are captured.
REQ-016 Arbitration: round-robin with a 1-bit priority pointer.
  - If both requesters are valid, grant the one the pointer names.
  - If one is valid, grant it regardless of the pointer.
  - The pointer moves to the non-granted requester at acceptance.
REQ-017 reqX_ready shall be low in RUN and DONE, and low for the non-granted requester.
REQ-018 RUN: internal shift-add multiply, one multiplier bit per cycle, LSB first.
  - Each cycle conditionally adds the multiplicand and shifts the product register right.
  - Iteration counter is log2(N)+1 bits.
  - Exactly N cycles in RUN, then go to DONE.
REQ-019 Latency: acceptance at edge t gives res_valid high after edge t+N+1; zero operands take the same time (no early exit).
REQ-020 Arithmetic: unsigned, full 2*N-bit product, no truncation or overflow.
REQ-021 DONE: res_valid=1 while res_data and res_id are held stable; leave on res_valid and res_ready, then return to IDLE.
REQ-022 Back-to-back: the transaction after DONE is accepted no earlier than the cycle after the DONE exit, since the IDLE grant happens in IDLE.
REQ-023 res_data and res_id shall hold their last value in IDLE; they are meaningful only while res_valid is high.
REQ-024 Operand inputs and reqX_valid changes during RUN/DONE shall have no effect.
REQ-025 Requesters shall not be starved: with both requesters continuously valid, grants alternate 0,1,0,1.

Reset
REQ-026 On reset high at a clock edge, regardless of state (including mid-RUN or DONE):
  - state=IDLE, priority pointer=0;
  - product, operand and counter registers cleared;
  - res_valid=0, res_id=0, res_data=0, busy=0, req0_ready=req1_ready=0 in the following cycle.
REQ-027 A transaction aborted by reset shall produce no result.
REQ-028 reqX_ready shall be low while reset is high.

Verification
REQ-029 Single request: N=32, req0 a=7, b=6 -> req0_ready for 1 cycle; res_valid 33 cycles later; res_data=42, res_id=0.
REQ-030 Max operands: req1 a=b=0xFFFFFFFF -> res_data=0xFFFFFFFE00000001, res_id=1.
REQ-031 Contention: both valid continuously after reset, res_ready=1 -> grants and res_id sequence 0,1,0,1; neither ready high in the same cycle.
REQ-032 Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid, res_data, res_id stable; no new acceptance; exit one cycle after res_ready=1.
REQ-033 Reset mid-operation: reset at RUN cycle 15 of a 7*6 request -> next cycle all outputs 0, IDLE; a following req1 3*5 request -> res_data=15, res_id=1, with no stale 42.
REQ-034 Zero operand: req0 a=0, b=0x12345678 -> res_data=0 with the full N+1 cycle latency.
